rqst_pc_dispatcher: RTL and testbench

Parametrised successor to the PC request handler. Accepts request words written by the PC through a valid/ready handshake and decodes NUM_RQST request bits. Each request is held as a level until the target module acknowledges it or a timeout expires. Also maintains the sticky run state and sits between the PC register bank and the start/reset/stop/conf consumers.

---
 rtl/rqst_pc_dispatcher.sv | 206 ++++++++++++++++++++
 tb/tb_rqst_pc_dispatcher.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rqst_pc_dispatcher.sv
// PC request dispatcher: decodes request words into held request levels with ack/timeout release.
// Optional RQST_QUEUE_EN puts a QUEUE_DEPTH-entry FIFO of masked words in front of the FSM.
module rqst_pc_dispatcher #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_RQST       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned QUEUE_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rqst_data,
  input  logic                  rqst_valid,
  output logic                  rqst_ready,
  output logic [NUM_RQST-1:0]   rqst_o,
  input  logic [NUM_RQST-1:0]   ack_i,
  output logic                  running_o,
  output logic                  conflict_o,
  output logic                  timeout_o,
  output logic [NUM_RQST-1:0]   timeout_mask_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast =
      (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_RQST-1:0] pending_q, pending_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                running_q, running_d;
  logic                conflict_q, conflict_d;
  logic                timeout_q, timeout_d;
  logic [NUM_RQST-1:0] tmask_q, tmask_d;

  logic [NUM_RQST-1:0] word_raw, word_masked;
  logic                word_conflict, word_nonzero;
  logic                in_fire;
  logic                load;
  logic [NUM_RQST-1:0] load_word;
  logic [NUM_RQST-1:0] pending_acked;

  // Bits above NUM_RQST carry no request meaning.
  logic unused_data;
  assign unused_data = ^rqst_data;

  // Stop and reset both override start; only start+stop is flagged as a conflict.
  always_comb begin
    word_raw      = rqst_data[NUM_RQST-1:0];
    word_masked   = word_raw;
    word_conflict = word_raw[0] & word_raw[2];
    if (word_raw[2] || word_raw[1]) begin
      word_masked[0] = 1'b0;
    end
    word_nonzero = |word_masked;
  end

  assign in_fire = rqst_valid & rqst_ready & word_nonzero;

  always_comb begin
    running_d  = running_q;
    conflict_d = in_fire & word_conflict;
    if (in_fire) begin
      if (word_masked[2] || word_masked[1]) begin
        running_d = 1'b0;
      end else if (word_masked[0]) begin
        running_d = 1'b1;
      end
    end
  end

`ifdef RQST_QUEUE_EN
  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [NUM_RQST-1:0] mem_q [QUEUE_DEPTH];
  logic [NUM_RQST-1:0] mem_d [QUEUE_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d;
  logic                q_full, q_empty, q_push, q_pop;

  assign q_full     = (count_q == (PtrW + 1)'(QUEUE_DEPTH));
  assign q_empty    = (count_q == '0);
  assign rqst_ready = ~q_full;
  assign q_push     = in_fire;
  assign q_pop      = (state_q == StIdle) & ~q_empty;
  assign load       = q_pop;
  assign load_word  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q_push) begin
      mem_d[wr_ptr_q] = word_masked;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (q_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({q_push, q_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`else
  assign rqst_ready = (state_q == StIdle);
  assign load       = in_fire;
  assign load_word  = word_masked;
`endif

  assign pending_acked = pending_q & ~ack_i;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    tmask_d   = tmask_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          pending_d = load_word;
          tmask_d   = '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        pending_d = pending_acked;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        if (pending_acked == '0) begin
          pending_d = '0;
          state_d   = StIdle;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          // An ack landing on the timeout cycle still retires its own bit.
          tmask_d   = pending_acked;
          pending_d = '0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          pending_d = pending_acked;
        end
      end
      default: begin
        pending_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      cnt_q      <= '0;
      running_q  <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      tmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      tmask_q    <= tmask_d;
    end
  end

  // Pending is always zero in IDLE, so it doubles as the request level.
  assign rqst_o         = pending_q;
  assign running_o      = running_q;
  assign conflict_o     = conflict_q;
  assign timeout_o      = timeout_q;
  assign timeout_mask_o = tmask_q;

endmodule

// File: tb/tb_rqst_pc_dispatcher.sv
// Directed bench for rqst_pc_dispatcher (default build, TIMEOUT_CYCLES=8).
module tb_rqst_pc_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rqst_data;
  logic        rqst_valid;
  logic        rqst_ready;
  logic [3:0]  rqst_o;
  logic [3:0]  ack_i;
  logic        running_o;
  logic        conflict_o;
  logic        timeout_o;
  logic [3:0]  timeout_mask_o;

  int n_total = 0;
  int n_pass  = 0;

  rqst_pc_dispatcher #(
    .DATA_WIDTH    (16),
    .NUM_RQST      (4),
    .TIMEOUT_CYCLES(8),
    .QUEUE_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rqst_data     (rqst_data),
    .rqst_valid    (rqst_valid),
    .rqst_ready    (rqst_ready),
    .rqst_o        (rqst_o),
    .ack_i         (ack_i),
    .running_o     (running_o),
    .conflict_o    (conflict_o),
    .timeout_o     (timeout_o),
    .timeout_mask_o(timeout_mask_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst        = 1'b1;
    rqst_data  = '0;
    rqst_valid = 1'b0;
    ack_i      = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_rqst", 32'(rqst_o), 32'h0);
    check("reset_running", 32'(running_o), 32'h0);
    check("reset_conflict", 32'(conflict_o), 32'h0);
    check("reset_timeout", 32'(timeout_o), 32'h0);
    check("reset_tmask", 32'(timeout_mask_o), 32'h0);
    check("reset_ready", 32'(rqst_ready), 32'h1);

    // Start word: accepted at k, ack at k+3.
    rqst_data  = 16'h0001;
    rqst_valid = 1'b1;
    tick();
    rqst_valid = 1'b0;
    check("start_rqst_k1", 32'(rqst_o), 32'h1);
    check("start_running_k1", 32'(running_o), 32'h1);
    check("start_ready_k1", 32'(rqst_ready), 32'h0);
    tick();
    check("start_rqst_k2", 32'(rqst_o), 32'h1);
    tick();
    ack_i = 4'h1;
    check("start_rqst_k3", 32'(rqst_o), 32'h1);
    tick();
    ack_i = 4'h0;
    check("start_rqst_k4", 32'(rqst_o), 32'h0);
    check("start_ready_k4", 32'(rqst_ready), 32'h1);
    check("start_running_k4", 32'(running_o), 32'h1);

    // Start+stop: stop wins, conflict pulses once.
    rqst_data  = 16'h0005;
    rqst_valid = 1'b1;
    tick();
    rqst_valid = 1'b0;
    check("conf_rqst", 32'(rqst_o), 32'h4);
    check("conf_pulse", 32'(conflict_o), 32'h1);
    check("conf_running", 32'(running_o), 32'h0);
    tick();
    check("conf_pulse_end", 32'(conflict_o), 32'h0);
    ack_i = 4'h4;
    tick();
    ack_i = 4'h0;
    check("conf_rqst_done", 32'(rqst_o), 32'h0);
    check("conf_ready_done", 32'(rqst_ready), 32'h1);

    // All bits: bit0 masked, acks retire bits 3, 1, 2 one at a time.
    rqst_data  = 16'h000F;
    rqst_valid = 1'b1;
    tick();
    rqst_valid = 1'b0;
    check("all_rqst_issue", 32'(rqst_o), 32'hE);
    check("all_conflict", 32'(conflict_o), 32'h1);
    tick();
    check("all_rqst_wait", 32'(rqst_o), 32'hE);
    ack_i = 4'h8;
    tick();
    check("all_after_ack3", 32'(rqst_o), 32'h6);
    check("all_ready_ack3", 32'(rqst_ready), 32'h0);
    ack_i = 4'h2;
    tick();
    check("all_after_ack1", 32'(rqst_o), 32'h4);
    check("all_ready_ack1", 32'(rqst_ready), 32'h0);
    ack_i = 4'h4;
    tick();
    ack_i = 4'h0;
    check("all_after_ack2", 32'(rqst_o), 32'h0);
    check("all_ready_done", 32'(rqst_ready), 32'h1);

    // Conf word with no ack: times out after 8 WAIT cycles.
    rqst_data  = 16'h0008;
    rqst_valid = 1'b1;
    tick();
    rqst_valid = 1'b0;
    check("to_rqst_issue", 32'(rqst_o), 32'h8);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("to_no_pulse_yet", 32'(timeout_o), 32'h0);
    end
    check("to_rqst_held", 32'(rqst_o), 32'h8);
    tick();
    check("to_pulse", 32'(timeout_o), 32'h1);
    check("to_mask", 32'(timeout_mask_o), 32'h8);
    check("to_rqst_drop", 32'(rqst_o), 32'h0);
    check("to_ready", 32'(rqst_ready), 32'h1);
    tick();
    check("to_pulse_end", 32'(timeout_o), 32'h0);
    check("to_mask_hold", 32'(timeout_mask_o), 32'h8);

    // Next nonzero word clears the timeout mask; ack during ISSUE is honoured.
    rqst_data  = 16'h0001;
    rqst_valid = 1'b1;
    tick();
    rqst_valid = 1'b0;
    check("clr_mask", 32'(timeout_mask_o), 32'h0);
    check("clr_running", 32'(running_o), 32'h1);
    ack_i = 4'h1;
    tick();
    ack_i = 4'h0;
    check("issue_ack_rqst", 32'(rqst_o), 32'h0);
    check("issue_ack_busy", 32'(rqst_ready), 32'h0);
    tick();
    check("issue_ack_idle", 32'(rqst_ready), 32'h1);

    // Reset request with ignored upper bit, then rst during WAIT.
    rqst_data  = 16'h0012;
    rqst_valid = 1'b1;
    tick();
    rqst_valid = 1'b0;
    check("rstw_running", 32'(running_o), 32'h0);
    tick();
    check("rstw_rqst", 32'(rqst_o), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_rqst_clr", 32'(rqst_o), 32'h0);
    check("rstw_ready", 32'(rqst_ready), 32'h1);
    check("rstw_tmask", 32'(timeout_mask_o), 32'h0);
    check("rstw_timeout", 32'(timeout_o), 32'h0);

    // Zero and ignored-bit-only words are discarded.
    rqst_data  = 16'h0000;
    rqst_valid = 1'b1;
    tick();
    check("zero_rqst", 32'(rqst_o), 32'h0);
    check("zero_ready", 32'(rqst_ready), 32'h1);
    rqst_data = 16'h00F0;
    tick();
    rqst_valid = 1'b0;
    check("hi_rqst", 32'(rqst_o), 32'h0);
    check("hi_ready", 32'(rqst_ready), 32'h1);
    check("hi_running", 32'(running_o), 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
